// File: rtl/alpha_pkg.sv
// Shared types and helpers for the alpha blend pipeline.
// Holds the job FSM state enum and effective-alpha mapping.
package alpha_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int AW_DEF = 4;
    localparam int AMAX = 2**AW_DEF - 1;
    localparam int AONE = 2**AW_DEF;

    // Full-scale alpha maps to exactly one so that max alpha returns src.
    function automatic logic [15:0] a_eff_f(
        input logic [15:0] a,
        input int          aw
    );
        logic [15:0] amax;
        amax = 16'((1 << aw) - 1);
        return (a == amax) ? 16'(1 << aw) : a;
    endfunction

endpackage

// File: rtl/alpha_blend_if.sv
// Pixel stream bundle: input beat and result handshakes.
// Master drives beats and accepts results; slave is the blender.
interface alpha_blend_if #(
    parameter int CHANNELS = 3,
    parameter int CW       = 8,
    parameter int AW       = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CHANNELS*CW-1:0] src;
    logic [CHANNELS*CW-1:0] dst;
    logic [AW-1:0]          alpha;
    logic                   out_valid;
    logic                   out_ready;
    logic [CHANNELS*CW-1:0] result;

    modport master (
        output in_valid, src, dst, alpha, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, src, dst, alpha, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alpha_channel_mac.sv
// One colour channel: S1 multiply, S2 round/shift.
// ALPHA_BLEND_PREMULT_EN selects premultiplied source with saturation.
module alpha_channel_mac
    import alpha_pkg::*;
#(
    parameter int CW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          s1_en,
    input  logic          s2_en,
    input  logic [CW-1:0] src,
    input  logic [CW-1:0] dst,
    input  logic [AW:0]   a_eff,
    output logic [CW-1:0] result
);
    localparam int PW = CW + AW + 1;
    localparam logic [PW-1:0] ONE  = PW'(1) << AW;
    localparam logic [PW-1:0] HALF = PW'(1) << (AW - 1);

    logic [PW-1:0] inv;
    logic [PW-1:0] p_dst;
    logic [CW-1:0] nx;

    assign inv = ONE - PW'(a_eff);

`ifdef ALPHA_BLEND_PREMULT_EN
    logic [CW-1:0] p_src;
    logic [CW-1:0] dst_t;
    logic [CW:0]   sum;

    always_comb begin
        dst_t = CW'((p_dst + HALF) >> AW);
        sum   = {1'b0, p_src} + {1'b0, dst_t};
        nx    = sum[CW] ? '1 : sum[CW-1:0];
    end
`else
    logic [PW-1:0] p_src;

    assign nx = CW'((p_src + p_dst + HALF) >> AW);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p_src  <= '0;
            p_dst  <= '0;
            result <= '0;
        end else begin
            if (s1_en) begin
`ifdef ALPHA_BLEND_PREMULT_EN
                p_src <= src;
`else
                p_src <= PW'(src) * PW'(a_eff);
`endif
                p_dst <= PW'(dst) * inv;
            end
            if (s2_en) begin
                result <= nx;
            end
        end
    end

endmodule

// File: rtl/alpha_blend_pipe.sv
// Job-level alpha blender: FSM, beat counters, 2-stage valid pipe.
// ALPHA_BLEND_PREMULT_EN switches channels to premultiplied mode.
module alpha_blend_pipe
    import alpha_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int CW       = 8,
    parameter int AW       = 4,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            start,
    input  logic [CNTW-1:0] num_pixels,
    alpha_blend_if.slave    bus,
    output logic            busy,
    output logic            done
);
    localparam int AEW = AW + 1;

    state_t state, state_nx;

    logic [CNTW-1:0] total;
    logic [CNTW-1:0] in_cnt;
    logic [CNTW-1:0] out_cnt;
    logic            s1_v, s2_v;
    logic            s2_ld, s1_ok;
    logic            in_fire, out_fire;
    logic            last_out, job_go;
    logic [AW:0]     a_eff;

    // S2 can take a beat when empty or draining this cycle.
    assign s2_ld    = !s2_v || bus.out_ready;
    assign s1_ok    = !s1_v || s2_ld;
    assign job_go   = (state == IDLE) && start;

    assign bus.in_ready = (state == RUN)
                       && (in_cnt != total)
                       && s1_ok;

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_v && bus.out_ready;
    assign last_out = out_fire
                   && (out_cnt == total - CNTW'(1));

    assign bus.out_valid = s2_v;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    assign a_eff = AEW'(a_eff_f(16'(bus.alpha), AW));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (num_pixels != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_out) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            total   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
        end else begin
            state <= state_nx;
            if (job_go) begin
                total   <= num_pixels;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (in_fire) begin
                    in_cnt <= in_cnt + CNTW'(1);
                end
                if (out_fire) begin
                    out_cnt <= out_cnt + CNTW'(1);
                end
            end
            s1_v <= in_fire || (s1_v && !s2_ld);
            if (s2_ld) begin
                s2_v <= s1_v;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        alpha_channel_mac #(
            .CW (CW),
            .AW (AW)
        ) u_mac (
            .clk    (clk),
            .n_rst  (n_rst),
            .s1_en  (in_fire),
            .s2_en  (s2_ld && s1_v),
            .src    (bus.src[c*CW +: CW]),
            .dst    (bus.dst[c*CW +: CW]),
            .a_eff  (a_eff),
            .result (bus.result[c*CW +: CW])
        );
    end

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Scoreboard bench for alpha_blend_pipe (3 x 8-bit, 4-bit alpha).
// Build with ALPHA_BLEND_PREMULT_EN to exercise premultiplied mode.
module tb_alpha_blend_pipe;
    import alpha_pkg::*;

    localparam int CH   = 3;
    localparam int CW   = 8;
    localparam int AW   = 4;
    localparam int CNTW = 16;
    localparam int PW   = CH * CW;

    logic            clk = 1'b0;
    logic            n_rst = 1'b1;
    logic            start = 1'b0;
    logic [CNTW-1:0] num_pixels = '0;
    logic            busy, done;

    alpha_blend_if #(.CHANNELS(CH), .CW(CW), .AW(AW)) bus();

    alpha_blend_pipe #(
        .CHANNELS (CH),
        .CW       (CW),
        .AW       (AW),
        .CNTW     (CNTW)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .num_pixels (num_pixels),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] exp_q[$];

    bit inf, outf, ir, ov, dn, bz;
    logic [PW-1:0] res;

    function automatic logic [PW-1:0] model(
        input logic [PW-1:0] s,
        input logic [PW-1:0] d,
        input logic [AW-1:0] a
    );
        int ae, sc, dc, v;
        logic [PW-1:0] r;
        ae = (int'(a) == AMAX) ? AONE : int'(a);
        r = '0;
        for (int c = 0; c < CH; c++) begin
            sc = int'(s[c*CW +: CW]);
            dc = int'(d[c*CW +: CW]);
`ifdef ALPHA_BLEND_PREMULT_EN
            v = sc + ((dc * (AONE - ae) + AONE / 2) / AONE);
            if (v > 255) v = 255;
`else
            v = (sc * ae + dc * (AONE - ae) + AONE / 2) / AONE;
`endif
            r[c*CW +: CW] = CW'(v);
        end
        return r;
    endfunction

    // Snapshot handshakes mid-cycle, then move to the next negedge.
    task automatic cyc();
        #1;
        ir   = bus.in_ready;
        ov   = bus.out_valid;
        inf  = bus.in_valid && bus.in_ready;
        outf = bus.out_valid && bus.out_ready;
        dn   = done;
        bz   = busy;
        res  = bus.result;
        @(negedge clk);
    endtask

    task automatic start_job(input logic [CNTW-1:0] n);
        start = 1'b1;
        num_pixels = n;
        cyc();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 n_rst = 1'b0;
        repeat (2) @(negedge clk);
        cyc();
        tests++;
        if (ir !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 0", ir);
        end
        tests++;
        if (ov !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got %b want 0", ov);
        end
        tests++;
        if (res !== '0) begin
            fails++;
            $display("FAIL reset_result got %h want 0", res);
        end
        tests++;
        if (bz !== 1'b0 || dn !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_done got %b%b want 00", bz, dn);
        end
        n_rst = 1'b1;
        cyc();
    endtask

    task automatic test_half_alpha();
        logic [PW-1:0] want;
`ifdef ALPHA_BLEND_PREMULT_EN
        want = 24'hFFFFFF;
`else
        want = 24'h808080;
`endif
        start_job(1);
        bus.src = 24'hFFFFFF;
        bus.dst = 24'h000000;
        bus.alpha = 4'd8;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        tests++;
        if (inf !== 1'b1) begin
            fails++;
            $display("FAIL half_accept got %b want 1", inf);
        end
        bus.in_valid = 1'b0;
        cyc();
        tests++;
        if (ov !== 1'b0) begin
            fails++;
            $display("FAIL half_early got %b want 0", ov);
        end
        cyc();
        tests++;
        if (ov !== 1'b1 || res !== want) begin
            fails++;
            $display("FAIL half_result got %b/%h want 1/%h",
                     ov, res, want);
        end
        cyc();
        tests++;
        if (dn !== 1'b1) begin
            fails++;
            $display("FAIL half_done got %b want 1", dn);
        end
        cyc();
        tests++;
        if (dn !== 1'b0 || bz !== 1'b0) begin
            fails++;
            $display("FAIL half_idle got %b%b want 00", dn, bz);
        end
    endtask

    task automatic test_alpha_extremes();
        int sent = 0, got = 0, budget = 0;
        logic [PW-1:0] s, d, want;
        logic [AW-1:0] a;
        s = PW'($urandom());
        d = PW'($urandom());
        a = '0;
        start_job(8);
        bus.src = s;
        bus.dst = d;
        bus.alpha = a;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        while (got < 8 && budget < 100) begin
            cyc();
            budget++;
            if (inf) begin
`ifdef ALPHA_BLEND_PREMULT_EN
                exp_q.push_back(model(s, d, a));
`else
                exp_q.push_back((a == '0) ? d : s);
`endif
                sent++;
                s = PW'($urandom());
                d = PW'($urandom());
                a = (sent % 2 == 1) ? AW'(AMAX) : '0;
                bus.src = s;
                bus.dst = d;
                bus.alpha = a;
                if (sent == 8) bus.in_valid = 1'b0;
            end
            if (outf) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extreme_result got %h want none", res);
                end else begin
                    want = exp_q.pop_front();
                    if (res !== want) begin
                        fails++;
                        $display("FAIL extreme_result got %h want %h",
                                 res, want);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (got != 8 || budget != 10) begin
            fails++;
            $display("FAIL extreme_rate got %0d in %0d cyc want 8 in 10",
                     got, budget);
        end
        cyc();
        tests++;
        if (dn !== 1'b1) begin
            fails++;
            $display("FAIL extreme_done got %b want 1", dn);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0, pulses = 0, last_k = -10;
        bit held_v = 1'b0;
        logic [PW-1:0] held, want, s, d;
        logic [AW-1:0] a;
        exp_q.delete();
        s = PW'($urandom());
        d = PW'($urandom());
        a = AW'($urandom());
        start_job(4);
        bus.src = s;
        bus.dst = d;
        bus.alpha = a;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.out_ready = (k % 4 == 0) || (k % 4 == 3);
            cyc();
            if (held_v) begin
                tests++;
                if (ov !== 1'b1 || res !== held) begin
                    fails++;
                    $display("FAIL stall_hold got %b/%h want 1/%h",
                             ov, res, held);
                end
            end
            held_v = ov && !bus.out_ready;
            held = res;
            if (inf) begin
                acc++;
                exp_q.push_back(model(s, d, a));
                s = PW'($urandom());
                d = PW'($urandom());
                a = AW'($urandom());
                bus.src = s;
                bus.dst = d;
                bus.alpha = a;
            end
            if (outf) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_result got %h want none", res);
                end else begin
                    want = exp_q.pop_front();
                    if (res !== want) begin
                        fails++;
                        $display("FAIL bp_result got %h want %h",
                                 res, want);
                    end
                end
                if (got == 4) last_k = k;
            end
            if (dn) begin
                pulses++;
                tests++;
                if (k != last_k + 1) begin
                    fails++;
                    $display("FAIL bp_done_time got %0d want %0d",
                             k, last_k + 1);
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tests++;
        if (acc != 4 || got != 4) begin
            fails++;
            $display("FAIL bp_counts got %0d/%0d want 4/4", acc, got);
        end
        tests++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL bp_done_count got %0d want 1", pulses);
        end
    endtask

    task automatic test_zero_job();
        bus.in_valid = 1'b1;
        start = 1'b1;
        num_pixels = '0;
        cyc();
        start = 1'b0;
        tests++;
        if (ir !== 1'b0) begin
            fails++;
            $display("FAIL zero_ready0 got %b want 0", ir);
        end
        cyc();
        tests++;
        if (dn !== 1'b1 || ir !== 1'b0) begin
            fails++;
            $display("FAIL zero_done got %b/%b want 1/0", dn, ir);
        end
        cyc();
        tests++;
        if (dn !== 1'b0 || bz !== 1'b0 || ir !== 1'b0) begin
            fails++;
            $display("FAIL zero_idle got %b%b%b want 000", dn, bz, ir);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_start_ignored();
        int acc = 0, got = 0, pulses = 0;
        logic [PW-1:0] want, s, d;
        logic [AW-1:0] a;
        exp_q.delete();
        s = PW'($urandom());
        d = PW'($urandom());
        a = AW'($urandom());
        start_job(3);
        bus.src = s;
        bus.dst = d;
        bus.alpha = a;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            start = (k == 2);
            num_pixels = 16'd1;
            cyc();
            if (inf) begin
                acc++;
                exp_q.push_back(model(s, d, a));
                s = PW'($urandom());
                d = PW'($urandom());
                a = AW'($urandom());
                bus.src = s;
                bus.dst = d;
                bus.alpha = a;
            end
            if (outf) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL ign_result got %h want none", res);
                end else begin
                    want = exp_q.pop_front();
                    if (res !== want) begin
                        fails++;
                        $display("FAIL ign_result got %h want %h",
                                 res, want);
                    end
                end
            end
            if (dn) begin
                pulses++;
                tests++;
                if (got != 3) begin
                    fails++;
                    $display("FAIL ign_done_early got %0d outs want 3",
                             got);
                end
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        tests++;
        if (acc != 3 || got != 3 || pulses != 1) begin
            fails++;
            $display("FAIL ign_counts got %0d/%0d/%0d want 3/3/1",
                     acc, got, pulses);
        end
    endtask

    task automatic test_reset_flush();
        int acc = 0, got = 0, k = 0;
        logic [PW-1:0] want, s, d;
        logic [AW-1:0] a;
        exp_q.delete();
        start_job(4);
        bus.src = PW'($urandom());
        bus.dst = PW'($urandom());
        bus.alpha = AW'($urandom());
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        while (acc < 2 && k < 10) begin
            cyc();
            k++;
            if (inf) acc++;
        end
        bus.in_valid = 1'b0;
        tests++;
        if (acc != 2) begin
            fails++;
            $display("FAIL flush_fill got %0d want 2", acc);
        end
        #2 n_rst = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL flush_now got %b%b%b want 000",
                     bus.out_valid, busy, done);
        end
        @(negedge clk);
        n_rst = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        s = PW'($urandom());
        d = PW'($urandom());
        a = AW'($urandom());
        start_job(1);
        bus.src = s;
        bus.dst = d;
        bus.alpha = a;
        bus.in_valid = 1'b1;
        k = 0;
        while (got == 0 && k < 10) begin
            cyc();
            k++;
            if (inf) begin
                exp_q.push_back(model(s, d, a));
                bus.in_valid = 1'b0;
            end
            if (outf) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL flush_stale got %h want none", res);
                end else begin
                    want = exp_q.pop_front();
                    if (res !== want) begin
                        fails++;
                        $display("FAIL flush_new got %h want %h",
                                 res, want);
                    end
                end
            end
        end
        tests++;
        if (got != 1) begin
            fails++;
            $display("FAIL flush_timeout got %0d want 1", got);
        end
        repeat (2) cyc();
    endtask

`ifdef ALPHA_BLEND_PREMULT_EN
    task automatic test_premult();
        int got = 0, k = 0;
        logic [PW-1:0] want;
        exp_q.delete();
        start_job(2);
        bus.src = 24'hC0C0C0;
        bus.dst = 24'h808080;
        bus.alpha = 4'd0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        while (got < 2 && k < 20) begin
            cyc();
            k++;
            if (inf) begin
                exp_q.push_back((exp_q.size() == 0 && got == 0)
                                ? 24'hFFFFFF : 24'hC0C0C0);
                bus.alpha = 4'd15;
            end
            if (outf) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL premult got %h want none", res);
                end else begin
                    want = exp_q.pop_front();
                    if (res !== want) begin
                        fails++;
                        $display("FAIL premult got %h want %h",
                                 res, want);
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        tests++;
        if (got != 2) begin
            fails++;
            $display("FAIL premult_timeout got %0d want 2", got);
        end
        repeat (2) cyc();
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.src = '0;
        bus.dst = '0;
        bus.alpha = '0;
        test_reset();
        test_half_alpha();
        test_alpha_extremes();
        test_backpressure();
        test_zero_job();
        test_start_ignored();
        test_reset_flush();
`ifdef ALPHA_BLEND_PREMULT_EN
        test_premult();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/alpha_blend_pipe.md
# alpha_blend_pipe

Parametrised, pipelined multi-channel alpha blender that replaces the single-channel blend controller/datapath pair. It accepts a job of N pixels under a start/done handshake and streams source/destination pixel pairs through valid/ready handshakes. It emits blended pixels two cycles after acceptance, with full backpressure support. It sits between the frame-buffer read unit and the write-back unit in the 2D raster path.

## Interface
- CHANNELS, default 3: colour channels per pixel.
- CW, default 8: bits per channel.
- AW, default 4: alpha width; alpha range 0..2^AW-1.
- CNTW, default 16: width of the job pixel count.
- clk  in  1: single clock, rising edge.
- n_rst  in  1: asynchronous, active-low reset.
- start  in  1: job start pulse; sampled only in IDLE.
- num_pixels  in  CNTW: pixels in the job; sampled with start.
- in_valid  in  1: src/dst/alpha are valid.
- in_ready  out  1: block accepts the input beat.
- src  in  CHANNELS*CW: source pixel; channel 0 in the LSBs.
- dst  in  CHANNELS*CW: destination pixel.
- alpha  in  AW: per-pixel alpha, applied to all channels.
- out_valid  out  1: result is valid.
- out_ready  in  1: downstream accepts the result.
- result  out  CHANNELS*CW: blended pixel.
- busy  out  1: a job is in progress.
- done  out  1: one-cycle pulse after the last result handshake.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE -> RUN on start with num_pixels != 0.
  - IDLE -> DONE on start with num_pixels == 0.
  - RUN -> DONE on the output handshake of beat num_pixels.
  - DONE -> IDLE unconditionally after one cycle.
- busy = (state != IDLE). done = (state == DONE).
- An input counter counts accepted beats. in_ready is deasserted once num_pixels beats have been accepted, so extra input is never consumed.
- An output counter counts out_valid && out_ready handshakes. Both counters reload to 0 on start.
- Per-channel blend math:
  - a_eff = 2^AW when alpha == 2^AW-1, otherwise alpha.
  - result_ch = (src_ch*a_eff + dst_ch*(2^AW - a_eff) + 2^(AW-1)) >> AW.
  - Products are CW+AW+1 bits wide; the sum cannot overflow CW bits.
- alpha == 0 gives exactly dst; alpha == max gives exactly src.
- start outside IDLE is ignored. in_valid outside RUN is ignored, and in_ready is 0 outside RUN.

## Timing
- Pipeline has two stages:
  - S1 registers the per-channel products and a_eff.
  - S2 registers the rounded, shifted sum and drives result/out_valid.
- Latency is 2 cycles from the input handshake to out_valid with no stall. Throughput is 1 pixel per cycle.
- Stall rule: when out_valid && !out_ready, S2 holds. S1 advances only if S2 is empty or draining.
- in_ready = (state == RUN) && inputs remaining && (S1 empty || S1 advancing). It is combinational from out_ready; no extra bubble is inserted.
- result holds stable while out_valid && !out_ready.
- Simultaneous input and output handshakes in the same cycle are both honoured.
- done asserts the cycle after the final output handshake.
- Reset values: in_ready 0, out_valid 0, result 0, busy 0, done 0, FSM IDLE, counters 0, pipeline valid bits 0.
- Reset asserted mid-job flushes the pipeline immediately and emits no done.

## Configuration
- Macro ALPHA_BLEND_PREMULT_EN enables premultiplied-source mode.
- With the macro defined:
  - result_ch = sat_CW(src_ch + ((dst_ch*(2^AW - a_eff) + 2^(AW-1)) >> AW)).
  - The sum is CW+1 bits and saturates to 2^CW-1.
- Without the macro, the straight-alpha formula above applies and the saturation logic is absent.
- Latency is identical in both modes.

## Structure
- Package alpha_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - localparams AMAX = 2^AW-1 and AONE = 2^AW;
  - a function computing a_eff.
- Sub-module alpha_channel_mac: one instance per channel via generate. It holds the S1 multiply and S2 round/shift (and saturation when enabled).
- The top level owns the FSM, counters and handshake/valid pipeline.

## Test plan
- CHANNELS=3, CW=8, AW=4: src 0xFFFFFF, dst 0x000000, alpha 8 -> result 0x808080 two cycles after acceptance.
- alpha 0 -> result equals dst exactly; alpha 15 -> result equals src exactly, for random src/dst.
- Job of 4 pixels with in_valid held high and out_ready toggling 1,0,0,1,... -> results arrive in order and unchanged while stalled. in_ready drops after the 4th accepted beat. done pulses once, one cycle after the 4th output handshake.
- start with num_pixels 0 -> done pulses the next-but-one cycle, in_ready never asserts; start asserted during RUN -> ignored, counters unchanged.
- n_rst asserted with 2 beats in flight -> out_valid, busy and done are 0 immediately. A new job after reset produces no stale result.
- With ALPHA_BLEND_PREMULT_EN: src 0xC0 per channel, dst 0x80, alpha 0 -> result 0xFF per channel (saturated). Same src/dst with alpha 15 -> 0xC0.
